mem_stage: RTL

- MEM stage of the 5-stage RV32 pipeline, directly downstream of the EX/MEM register.
- Consumes the registered ALU result, rd/write-back enable and store data.
- Runs load/store transactions on the data-memory port with a req/ready handshake, aligns and sign-extends load data, and produces the MEM/WB register.
- Raises a stall to freeze upstream stages while an access waits.

---
 rtl/mem_stage_if.sv | 22 ++
 rtl/mem_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// Data-memory port of the MEM stage: request/ready handshake plus address/data lanes.
interface mem_stage_if #(
  parameter int unsigned DM_AW = 14
);
  logic             dm_req;
  logic             dm_we;
  logic [DM_AW-1:0] dm_addr;
  logic [31:0]      dm_wdata;
  logic [3:0]       dm_be;
  logic [31:0]      dm_rdata;
  logic             dm_ready;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_rdata, dm_ready
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_rdata, dm_ready
  );
endinterface

// File: rtl/mem_stage.sv
// RV32 MEM stage: load/store over a req/ready memory port, load alignment, MEM/WB register.
// Optional MISALIGN_TRAP_EN adds misalign_err and suppresses misaligned accesses.
module mem_stage #(
  parameter int unsigned DM_AW        = 14,
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         alu_out_mem,
  input  logic [31:0]         store_data_mem,
  input  logic [4:0]          rd_addr_mem,
  input  logic                wb_en_mem,
  input  logic                mem_rd_mem,
  input  logic                mem_wr_mem,
  input  logic [2:0]          funct3_mem,
  mem_stage_if.master         dm,
  output logic                stall_mem,
  output logic [4:0]          rd_addr_wb,
  output logic                wb_en_wb,
  output logic [31:0]         wb_data_wb,
  output logic                bus_err
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                misalign_err
`endif
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(WAIT_TIMEOUT - 1);

  state_t      state, state_n;
  logic [15:0] wait_cnt;
  logic        access;
  logic        misalign;
  logic        req_ok;
  logic        dm_req_c;
  logic        timeout_abort;
  logic [1:0]  addr_lo;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [3:0]  st_be;

  assign access  = mem_rd_mem | mem_wr_mem;
  assign addr_lo = alu_out_mem[1:0];

`ifdef MISALIGN_TRAP_EN
  logic is_half;
  logic is_word;
  assign is_half  = mem_rd_mem ? (funct3_mem == 3'b001 || funct3_mem == 3'b101)
                               : (funct3_mem == 3'b001);
  assign is_word  = (funct3_mem == 3'b010);
  assign misalign = access & ((is_half & addr_lo[0]) | (is_word & (addr_lo != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign req_ok = access & ~misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE) wait_cnt <= '0;
      else               wait_cnt <= wait_cnt + 16'd1;
    end
  end

  always_comb begin
    state_n       = state;
    dm_req_c      = 1'b0;
    timeout_abort = 1'b0;
    case (state)
      IDLE: begin
        dm_req_c = req_ok;
        if (req_ok && !dm.dm_ready) state_n = WAIT;
      end
      WAIT: begin
        dm_req_c = 1'b1;
        if (dm.dm_ready) begin
          state_n = IDLE;
        end else if (wait_cnt == TO_LAST) begin
          timeout_abort = 1'b1;
          state_n       = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Gating with rst drops the request the instant reset asserts, even if access is still high.
  assign dm.dm_req  = dm_req_c & ~rst;
  assign stall_mem  = dm.dm_req & ~dm.dm_ready & ~timeout_abort;

  assign dm.dm_we   = mem_wr_mem;
  assign dm.dm_addr = alu_out_mem[DM_AW+1:2];

  always_comb begin
    dm.dm_wdata = store_data_mem;
    st_be       = 4'b1111;
    case (funct3_mem)
      3'b000: begin
        dm.dm_wdata = {4{store_data_mem[7:0]}};
        st_be       = 4'b0001 << addr_lo;
      end
      3'b001: begin
        dm.dm_wdata = {2{store_data_mem[15:0]}};
        st_be       = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        dm.dm_wdata = store_data_mem;
        st_be       = 4'b1111;
      end
    endcase
  end

  assign dm.dm_be = mem_wr_mem ? st_be : 4'b1111;

  always_comb begin
    case (addr_lo)
      2'd0:    ld_byte = dm.dm_rdata[7:0];
      2'd1:    ld_byte = dm.dm_rdata[15:8];
      2'd2:    ld_byte = dm.dm_rdata[23:16];
      default: ld_byte = dm.dm_rdata[31:24];
    endcase
    ld_half = addr_lo[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];
    case (funct3_mem)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = dm.dm_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_wb <= '0;
      wb_en_wb   <= 1'b0;
      wb_data_wb <= '0;
      bus_err    <= 1'b0;
    end else begin
      bus_err <= timeout_abort;
      if (stall_mem) begin
        wb_en_wb <= 1'b0;
      end else begin
        rd_addr_wb <= rd_addr_mem;
        wb_en_wb   <= wb_en_mem & ~timeout_abort & ~misalign;
        wb_data_wb <= mem_rd_mem ? ld_data : alu_out_mem;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_err <= 1'b0;
    else     misalign_err <= misalign;
  end
`endif

endmodule
